// File: rtl/dec_92_2_seq_pkg.sv
// Shared definitions for the 92->2 decoder dense layer: sizes, Q8.8
// fixed-point helpers, FSM encoding and flattened weight indexing.
package dec_92_2_seq_pkg;

  localparam int BITSIZE   = 16;
  localparam int FRAC_BITS = 8;
  localparam int IN_SIZE   = 92;
  localparam int OUT_SIZE  = 2;
  localparam int IDX_W     = $clog2(IN_SIZE);

  localparam logic [BITSIZE-1:0] Q_ZERO = 16'h0000;
  localparam logic [BITSIZE-1:0] Q_ONE  = 16'h0100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Position of weight (o,i) in the flattened weight bus, in words.
  function automatic int flat_w_index(input int o, input int i, input int in_size);
    return o * in_size + i;
  endfunction

  // Signed Q8.8 multiply: full-precision product, truncated back to Q8.8.
  function automatic logic [BITSIZE-1:0] fixed_point_multiply(
    input logic [BITSIZE-1:0] a,
    input logic [BITSIZE-1:0] c
  );
    logic signed [2*BITSIZE-1:0] prod;
    prod = $signed(a) * $signed(c);
    return prod[FRAC_BITS +: BITSIZE];
  endfunction

  // Signed Q8.8 add with plain two's-complement wrap (no saturation).
  function automatic logic [BITSIZE-1:0] fixed_point_add(
    input logic [BITSIZE-1:0] a,
    input logic [BITSIZE-1:0] c
  );
    return a + c;
  endfunction

endpackage

// File: rtl/dec_92_2_seq_mac_lane.sv
// One output lane of the decoder: a Q8.8 multiply-accumulate with an
// accumulator that is preloaded with the bias at the start of a run.
module dec_mac_lane
  import dec_92_2_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               acc_en,
  input  logic [BITSIZE-1:0] bias,
  input  logic [BITSIZE-1:0] x_val,
  input  logic [BITSIZE-1:0] w_val,
  output logic [BITSIZE-1:0] sum
);

  logic [BITSIZE-1:0] acc_r;
  logic [BITSIZE-1:0] prod_s;
  logic [BITSIZE-1:0] sum_s;

  // Product of the current feature and weight plus the running total.
  always_comb begin
    prod_s = fixed_point_multiply(x_val, w_val);
    sum_s  = fixed_point_add(prod_s, acc_r);
  end

  // Accumulator: bias load at run start, otherwise accumulate when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= Q_ZERO;
    end else if (load) begin
      acc_r <= bias;
    end else if (acc_en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign sum = sum_s;

endmodule

// File: rtl/dec_92_2_seq.sv
// Decoder-side dense layer y = W*x + b (92 inputs -> 2 outputs), one input
// feature per cycle with both outputs accumulated in parallel lanes.
module dec_92_2_seq
  import dec_92_2_seq_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BITSIZE*IN_SIZE-1:0]          x,
  input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
  input  logic [BITSIZE*OUT_SIZE-1:0]         b,
  output logic [BITSIZE*OUT_SIZE-1:0]         y,
  output logic                                busy,
  output logic                                done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_SIZE - 1);

  state_e                            state_r;
  state_e                            state_next_s;
  logic [IDX_W-1:0]                  idx_r;
  logic [IDX_W-1:0]                  idx_next_s;
  logic                              load_s;
  logic                              acc_en_s;
  logic                              last_s;
  logic                              busy_r;
  logic                              done_r;
  logic [BITSIZE-1:0]                x_sel_s;
  logic [OUT_SIZE-1:0][BITSIZE-1:0]  sum_s;
  logic [OUT_SIZE-1:0][BITSIZE-1:0]  y_r;

  // Next-state, index and lane-control decode.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    load_s       = 1'b0;
    acc_en_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          idx_next_s   = {IDX_W{1'b0}};
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_en_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          last_s       = 1'b1;
          state_next_s = ST_IDLE;
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          idx_next_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, index and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= last_s;
    end
  end

  // Select the input feature addressed by the current index.
  always_comb begin
    x_sel_s = x[int'(idx_r)*BITSIZE +: BITSIZE];
  end

  for (genvar o = 0; o < OUT_SIZE; o++) begin : g_lane
    logic [BITSIZE-1:0] w_sel_s;

    // Select weight (o, idx) from the flattened weight bus.
    always_comb begin
      w_sel_s = w[flat_w_index(o, int'(idx_r), IN_SIZE)*BITSIZE +: BITSIZE];
    end

    dec_mac_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .acc_en (acc_en_s),
      .bias   (b[o*BITSIZE +: BITSIZE]),
      .x_val  (x_sel_s),
      .w_val  (w_sel_s),
      .sum    (sum_s[o])
    );
  end

  // Result register: captures the final sums on the completion edge only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_r <= '0;
    end else if (last_s) begin
      y_r <= sum_s;
    end else begin
      y_r <= y_r;
    end
  end

  assign y    = y_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_dec_92_2_seq.sv
// Self-checking bench for dec_92_2_seq: scoreboard of expected results,
// one task per scenario.
module tb_dec_92_2_seq;

  localparam int BS = 16;
  localparam int NI = 92;
  localparam int NO = 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic [BS*NI-1:0]   x;
  logic [BS*NO*NI-1:0] w;
  logic [BS*NO-1:0]   b;
  logic [BS*NO-1:0]   y;
  logic               busy;
  logic               done;

  logic [15:0] xs [NI];
  logic [15:0] ws [NO][NI];
  logic [15:0] bs [NO];

  logic [31:0] sb_q[$];   // expected {y1, y0}

  int checks   = 0;
  int failures = 0;

  dec_92_2_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .w     (w),
    .b     (b),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-element arrays onto the flat buses.
  task automatic pack();
    for (int i = 0; i < NI; i++) begin
      x[i*BS +: BS] = xs[i];
      for (int o = 0; o < NO; o++) w[(o*NI+i)*BS +: BS] = ws[o][i];
    end
    for (int o = 0; o < NO; o++) b[o*BS +: BS] = bs[o];
  endtask

  task automatic fill(input logic [15:0] xv, input logic [15:0] w0v, input logic [15:0] w1v,
                      input logic [15:0] b0v, input logic [15:0] b1v);
    for (int i = 0; i < NI; i++) begin
      xs[i] = xv; ws[0][i] = w0v; ws[1][i] = w1v;
    end
    bs[0] = b0v; bs[1] = b1v;
    pack();
  endtask

  // Reference Q8.8 arithmetic: arithmetic shift of the 32-bit product.
  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] c);
    int p;
    p = $signed(a) * $signed(c);
    return 16'(p >>> 8);
  endfunction

  function automatic logic [31:0] model();
    logic [15:0] acc [NO];
    for (int o = 0; o < NO; o++) begin
      acc[o] = bs[o];
      for (int i = 0; i < NI; i++) acc[o] = acc[o] + m_mul(xs[i], ws[o][i]);
    end
    return {acc[1], acc[0]};
  endfunction

  // Pulse start for one edge (E0) and record the expected result.
  task automatic kick(input logic [31:0] exp_y);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb_q.push_back(exp_y);
  endtask

  // Count negedges after E0 until done; no comparisons here.
  task automatic wait_done(output int done_at, output int busy_cnt, output bit timed_out);
    done_at = 0; busy_cnt = 0; timed_out = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = n; timed_out = 1'b0;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;             // asserted at t=2, before any rising edge
    #1;
    checks++; if (y !== 32'h0) begin failures++; $display("FAIL reset_y got=%h exp=%h", y, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sparse(input string tag);
    int da, bc; bit to;
    logic [31:0] e;
    fill(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000);
    ws[0][5] = 16'h0200; ws[1][91] = 16'hFF00; pack();
    kick({16'hFF00, 16'h0280});
    wait_done(da, bc, to);
    checks++; if (to || da != 93) begin failures++; $display("FAIL %s_done_at got=%0d exp=93", tag, da); end
    checks++; if (bc != 92) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=92", tag, bc); end
    e = sb_q.pop_front();
    checks++; if (y[15:0] !== e[15:0]) begin failures++; $display("FAIL %s_y0 got=%h exp=%h", tag, y[15:0], e[15:0]); end
    checks++; if (y[31:16] !== e[31:16]) begin failures++; $display("FAIL %s_y1 got=%h exp=%h", tag, y[31:16], e[31:16]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", tag, done); end
  endtask

  task automatic test_dense();
    int da, bc; bit to;
    logic [31:0] e;
    fill(16'h0010, 16'h0100, 16'h0080, 16'h0000, 16'h0000);
    kick({16'h02E0, 16'h05C0});
    wait_done(da, bc, to);
    e = sb_q.pop_front();
    checks++; if (to || y !== e) begin failures++; $display("FAIL dense_y got=%h exp=%h", y, e); end
  endtask

  task automatic test_handshake();
    int da, bc; bit to;
    logic [31:0] e;
    logic [31:0] y_prev;
    fill(16'h0010, 16'h0100, 16'h0080, 16'h0000, 16'h0000);
    kick({16'h02E0, 16'h05C0});
    y_prev = y;
    da = 0; to = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 30) start = 1'b1;
      if (n == 31) start = 1'b0;
      if (n > 1 && n < 93 && done !== 1'b1) begin
        checks++; if (y !== y_prev) begin failures++; $display("FAIL hs_y_hold got=%h exp=%h", y, y_prev); end
      end
      if (done === 1'b1) begin da = n; to = 1'b0; break; end
    end
    checks++; if (to || da != 93) begin failures++; $display("FAIL hs_done_at got=%0d exp=93", da); end
    e = sb_q.pop_front();
    checks++; if (y !== e) begin failures++; $display("FAIL hs_y_first got=%h exp=%h", y, e); end
    // Start during the done cycle: accepted as a back-to-back run.
    bs[0] = 16'h0100; pack();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb_q.push_back({16'h02E0, 16'h06C0});
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hs_b2b_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL hs_b2b_done got=%b exp=0", done); end
    wait_done(da, bc, to);
    checks++; if (to || da != 92) begin failures++; $display("FAIL hs_b2b_done_at got=%0d exp=92", da); end
    e = sb_q.pop_front();
    checks++; if (y !== e) begin failures++; $display("FAIL hs_y_second got=%h exp=%h", y, e); end
  endtask

  task automatic test_midrun_reset();
    fill(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000);
    ws[0][5] = 16'h0200; ws[1][91] = 16'hFF00; pack();
    kick({16'hFF00, 16'h0280});
    for (int n = 0; n < 40; n++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    sb_q.delete();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (y !== 32'h0) begin failures++; $display("FAIL mid_reset_y got=%h exp=0", y); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", done); end
    @(negedge clk);
    reset = 1'b0;
    test_sparse("post_reset");
  endtask

  task automatic test_wrap();
    int da, bc; bit to;
    logic [31:0] e;
    fill(16'h7F00, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    kick({16'h0000, 16'hA400});
    wait_done(da, bc, to);
    e = sb_q.pop_front();
    checks++; if (to || y[15:0] !== e[15:0]) begin failures++; $display("FAIL wrap_y0 got=%h exp=%h", y[15:0], e[15:0]); end
    checks++; if (y[31:16] !== e[31:16]) begin failures++; $display("FAIL wrap_y1 got=%h exp=%h", y[31:16], e[31:16]); end
  endtask

  task automatic test_random();
    int da, bc; bit to;
    logic [31:0] e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        xs[i] = 16'($urandom);
        ws[0][i] = 16'($urandom);
        ws[1][i] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      bs[0] = 16'($urandom); bs[1] = 16'($urandom);
      pack();
      kick(model());
      wait_done(da, bc, to);
      e = sb_q.pop_front();
      checks++; if (to || y !== e) begin failures++; $display("FAIL random_%0d_y got=%h exp=%h", r, y, e); end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    x = '0; w = '0; b = '0;
    #2;
    test_reset();
    test_sparse("sparse");
    test_dense();
    test_handshake();
    test_midrun_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
